change_dispenser: RTL

Payout controller that sits downstream of the vending controller and turns its per-transaction result (item code plus nickel/dime/quarter/dollar counts) into physical actuation. It drives the item motor once, then ejects coins one at a time, largest denomination first, through a hopper with a coin-sensed handshake. It reports busy/done status, the cents paid out so far in the current transaction, and a sticky fault on hopper timeout.

---
 rtl/change_dispenser.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Payout controller: vends the item once, then ejects change largest coin first.
// Optional CHANGE_DISPENSER_AUDIT_EN adds lifetime audit_cents/audit_vends outputs.
module change_dispenser #(
   parameter int PULSE_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [2:0] item_dispensed,
   input  logic       change_dollar,
   input  logic [1:0] change_quarters,
   input  logic [3:0] change_dimes,
   input  logic [4:0] change_nickels,
   output logic       vend_valid,
   output logic [2:0] vend_item,
   input  logic       vend_ack,
   output logic [3:0] coin_eject,
   input  logic       coin_sensed,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [7:0] coins_paid
`ifdef CHANGE_DISPENSER_AUDIT_EN
   ,
   output logic [15:0] audit_cents,
   output logic [7:0]  audit_vends
`endif
);

   localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + PULSE_CYCLES + 1);
   localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, VEND, PICK, PULSE, WAIT, DONE, FAULT
   } state_t;

   state_t          state;
   logic            n_dollar;
   logic [1:0]      n_quarter;
   logic [3:0]      n_dime;
   logic [4:0]      n_nickel;
   logic [1:0]      sel;
   logic            sense_hold;
   logic [PW-1:0]   pcnt;
   logic [TW-1:0]   tcnt;
   logic [1:0]      pick_sel;
   logic            pick_any;
   logic            take;
   logic [7:0]      value;

   always_comb begin
      pick_any = 1'b1;
      pick_sel = 2'd0;
      if (n_dollar)
         pick_sel = 2'd3;
      else if (n_quarter != '0)
         pick_sel = 2'd2;
      else if (n_dime != '0)
         pick_sel = 2'd1;
      else if (n_nickel == '0)
         pick_any = 1'b0;
   end

   always_comb begin
      value = 8'd5;
      unique case (sel)
         2'd3: value = 8'd100;
         2'd2: value = 8'd25;
         2'd1: value = 8'd10;
         2'd0: value = 8'd5;
      endcase
   end

   // A sense latched during the pulse is credited as the pulse ends.
   assign take = (state == PULSE && pcnt == P_LAST &&
                  (sense_hold || coin_sensed)) ||
                 (state == WAIT && coin_sensed);

`ifdef CHANGE_DISPENSER_AUDIT_EN
   logic [16:0] audit_sum;
   assign audit_sum = {1'b0, audit_cents} + {9'd0, value};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         n_dollar   <= 1'b0;
         n_quarter  <= '0;
         n_dime     <= '0;
         n_nickel   <= '0;
         sel        <= '0;
         sense_hold <= 1'b0;
         pcnt       <= '0;
         tcnt       <= '0;
         vend_valid <= 1'b0;
         vend_item  <= '0;
         coin_eject <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         coins_paid <= '0;
`ifdef CHANGE_DISPENSER_AUDIT_EN
         audit_cents <= '0;
         audit_vends <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  n_dollar   <= change_dollar;
                  n_quarter  <= change_quarters;
                  n_dime     <= change_dimes;
                  n_nickel   <= change_nickels;
                  coins_paid <= '0;
                  busy       <= 1'b1;
                  tcnt       <= '0;
                  if (item_dispensed <= 3'd5) begin
                     vend_valid <= 1'b1;
                     vend_item  <= item_dispensed;
                     state      <= VEND;
                  end else begin
                     state <= PICK;
                  end
               end
            end
            VEND: begin
               if (vend_ack) begin
                  vend_valid <= 1'b0;
                  state      <= PICK;
               end else if (tcnt == T_LAST) begin
                  vend_valid <= 1'b0;
                  fault      <= 1'b1;
                  state      <= FAULT;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            PICK: begin
               if (pick_any) begin
                  sel        <= pick_sel;
                  coin_eject <= 4'b0001 << pick_sel;
                  pcnt       <= '0;
                  tcnt       <= '0;
                  sense_hold <= 1'b0;
                  state      <= PULSE;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            PULSE: begin
               tcnt <= tcnt + 1'b1;
               if (coin_sensed)
                  sense_hold <= 1'b1;
               if (pcnt == P_LAST) begin
                  coin_eject <= '0;
                  state      <= take ? PICK : WAIT;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            WAIT: begin
               if (coin_sensed) begin
                  state <= PICK;
               end else if (tcnt == T_LAST) begin
                  fault <= 1'b1;
                  state <= FAULT;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            FAULT: begin
               state <= FAULT;
            end
            default: state <= IDLE;
         endcase

         // coins_paid wraps modulo 256 on a maximum payout.
         if (take) begin
            unique case (sel)
               2'd3: n_dollar  <= 1'b0;
               2'd2: n_quarter <= n_quarter - 1'b1;
               2'd1: n_dime    <= n_dime - 1'b1;
               2'd0: n_nickel  <= n_nickel - 1'b1;
            endcase
            coins_paid <= coins_paid + value;
`ifdef CHANGE_DISPENSER_AUDIT_EN
            audit_cents <= audit_sum[16] ? 16'hffff : audit_sum[15:0];
`endif
         end
`ifdef CHANGE_DISPENSER_AUDIT_EN
         if (state == VEND && vend_ack)
            audit_vends <= audit_vends + 1'b1;
`endif
      end
   end

endmodule
